serial_compare_ctrl: RTL and testbench

//   Sequencer for the bit-serial magnitude comparator datapath.
//   - Accepts two WIDTH-bit unsigned operands on a start strobe.
//   - Streams them LSB-first, one bit pair per clock, through an embedded serial compare FSM.
//   - Reports L/E/G with a busy/done handshake, so word-level logic can use the serial comparator without bit-level sequencing.

---
 rtl/serial_compare_ctrl_if.sv | 29 ++
 rtl/serial_compare_ctrl.sv | 87 ++++++++
 tb/tb_serial_compare_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_compare_ctrl_if.sv
// rtl/serial_compare_ctrl_if.sv - request/result bundle for the serial magnitude compare sequencer
interface serial_compare_ctrl_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             L;
  logic             E;
  logic             G;
  logic             ser_a;
  logic             ser_b;
  logic             ser_last;
  logic [CW-1:0]    bit_cnt;

  modport master (
    output start, a_in, b_in,
    input  busy, done, L, E, G, ser_a, ser_b, ser_last, bit_cnt
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, L, E, G, ser_a, ser_b, ser_last, bit_cnt
  );
endinterface

// File: rtl/serial_compare_ctrl.sv
// rtl/serial_compare_ctrl.sv - word-level sequencer around an LSB-first bit-serial magnitude compare
module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  serial_compare_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic ONE_BIT = (WIDTH == 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {REL_EQ, REL_LT, REL_GT} rel_t;

  state_t           state;
  rel_t             rel;
  rel_t             rel_nxt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;

  // Each later bit is more significant, so any difference overrides what came before.
  always_comb begin
    rel_nxt = rel;
    if (bus.ser_a != bus.ser_b) rel_nxt = bus.ser_a ? REL_GT : REL_LT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rel          <= REL_EQ;
      sh_a         <= '0;
      sh_b         <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.L        <= 1'b0;
      bus.E        <= 1'b0;
      bus.G        <= 1'b0;
      bus.ser_a    <= 1'b0;
      bus.ser_b    <= 1'b0;
      bus.ser_last <= 1'b0;
      bus.bit_cnt  <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          // DONE accepts a new request directly so back-to-back compares have no bubble.
          if (bus.start) begin
            bus.ser_a    <= bus.a_in[0];
            bus.ser_b    <= bus.b_in[0];
            sh_a         <= bus.a_in >> 1;
            sh_b         <= bus.b_in >> 1;
            bus.ser_last <= ONE_BIT;
            bus.bit_cnt  <= '0;
            bus.busy     <= 1'b1;
            rel          <= REL_EQ;
            state        <= S_SHIFT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          rel         <= rel_nxt;
          sh_a        <= sh_a >> 1;
          sh_b        <= sh_b >> 1;
          bus.bit_cnt <= bus.bit_cnt + CW'(1);
          if (bus.ser_last) begin
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            bus.L        <= (rel_nxt == REL_LT);
            bus.E        <= (rel_nxt == REL_EQ);
            bus.G        <= (rel_nxt == REL_GT);
            bus.ser_a    <= 1'b0;
            bus.ser_b    <= 1'b0;
            bus.ser_last <= 1'b0;
            state        <= S_DONE;
          end else begin
            bus.ser_a    <= sh_a[0];
            bus.ser_b    <= sh_b[0];
            bus.ser_last <= ((bus.bit_cnt + CW'(1)) == LAST);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// tb/tb_serial_compare_ctrl.sv - directed self-checking bench for serial_compare_ctrl
module tb_serial_compare_ctrl;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  serial_compare_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_compare_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 20) begin
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b1;
    bus.a_in  = 8'hAA;
    bus.b_in  = 8'h55;
    rst       = 1'b1;
    step();
    step();
    checks++;
    if ({bus.busy, bus.done, bus.L, bus.E, bus.G} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {bus.busy, bus.done, bus.L, bus.E, bus.G});
    end
    checks++;
    if ({bus.ser_a, bus.ser_b, bus.ser_last, bus.bit_cnt} !== 7'b0) begin
      errors++;
      $display("FAIL reset_serial: got %b expected 0000000", {bus.ser_a, bus.ser_b, bus.ser_last, bus.bit_cnt});
    end
    bus.start = 1'b0;
    rst       = 1'b0;
    step();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_equal();
    int cyc;
    do_start(8'h35, 8'h35);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL eq_busy_after_start: got %b expected 1", bus.busy);
    end
    wait_done(cyc);
    checks++;
    if (cyc != 8) begin
      errors++;
      $display("FAIL eq_latency: got %0d expected 8", cyc);
    end
    checks++;
    if ({bus.L, bus.E, bus.G, bus.busy} !== 4'b0100) begin
      errors++;
      $display("FAIL eq_result: got LEGbusy=%b expected 0100", {bus.L, bus.E, bus.G, bus.busy});
    end
    step();
    checks++;
    if ({bus.done, bus.L, bus.E, bus.G} !== 4'b0010) begin
      errors++;
      $display("FAIL eq_hold: got doneLEG=%b expected 0010", {bus.done, bus.L, bus.E, bus.G});
    end
  endtask

  task automatic test_msb_override();
    int cyc;
    do_start(8'h80, 8'h7F);
    wait_done(cyc);
    checks++;
    if (cyc != 8 || {bus.L, bus.E, bus.G} !== 3'b001) begin
      errors++;
      $display("FAIL msb_gt: got cyc=%0d LEG=%b expected cyc=8 LEG=001", cyc, {bus.L, bus.E, bus.G});
    end
    step();
  endtask

  task automatic test_less_serial();
    do_start(8'h00, 8'hFF);
    for (int i = 0; i < WIDTH; i++) begin
      checks++;
      if ({bus.busy, bus.ser_a, bus.ser_b, bus.ser_last} !== {1'b1, 1'b0, 1'b1, (i == WIDTH - 1)}) begin
        errors++;
        $display("FAIL lt_serial bit %0d: got busy/a/b/last=%b expected %b", i,
                 {bus.busy, bus.ser_a, bus.ser_b, bus.ser_last}, {1'b1, 1'b0, 1'b1, (i == WIDTH - 1)});
      end
      checks++;
      if (int'(bus.bit_cnt) != i) begin
        errors++;
        $display("FAIL lt_bit_cnt: got %0d expected %0d", bus.bit_cnt, i);
      end
      step();
    end
    checks++;
    if ({bus.done, bus.L, bus.E, bus.G} !== 4'b1100) begin
      errors++;
      $display("FAIL lt_result: got doneLEG=%b expected 1100", {bus.done, bus.L, bus.E, bus.G});
    end
    step();
  endtask

  task automatic test_start_while_busy();
    int dones = 0;
    do_start(8'h00, 8'hFF);
    for (int i = 0; i < 14; i++) begin
      if (i == 2) begin
        bus.start = 1'b1;
        bus.a_in  = 8'hFF;
        bus.b_in  = 8'h00;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) dones++;
      step();
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL busy_start_dones: got %0d expected 1", dones);
    end
    checks++;
    if ({bus.busy, bus.L, bus.E, bus.G} !== 4'b0100) begin
      errors++;
      $display("FAIL busy_start_result: got busyLEG=%b expected 0100", {bus.busy, bus.L, bus.E, bus.G});
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] pa [4] = '{8'h12, 8'hA5, 8'h3C, 8'h01};
    logic [WIDTH-1:0] pb [4] = '{8'h34, 8'h5A, 8'h3C, 8'h02};
    logic [2:0]       exp_leg [3] = '{3'b100, 3'b001, 3'b010};
    int cyc;
    int busy_drops;
    bus.start = 1'b1;
    bus.a_in  = pa[0];
    bus.b_in  = pb[0];
    step();
    bus.a_in = pa[1];
    bus.b_in = pb[1];
    for (int k = 0; k < 3; k++) begin
      cyc        = 0;
      busy_drops = 0;
      while (bus.done !== 1'b1 && cyc < 20) begin
        if (bus.busy !== 1'b1) busy_drops++;
        step();
        cyc++;
      end
      checks++;
      if (cyc != 8 || busy_drops != 0) begin
        errors++;
        $display("FAIL b2b_timing %0d: got cyc=%0d drops=%0d expected cyc=8 drops=0", k, cyc, busy_drops);
      end
      checks++;
      if ({bus.busy, bus.L, bus.E, bus.G} !== {1'b0, exp_leg[k]}) begin
        errors++;
        $display("FAIL b2b_result %0d: got busyLEG=%b expected %b", k, {bus.busy, bus.L, bus.E, bus.G},
                 {1'b0, exp_leg[k]});
      end
      if (k == 2) begin
        bus.start = 1'b0;
        step();
      end else begin
        step();
        bus.a_in = pa[k + 2];
        bus.b_in = pb[k + 2];
      end
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_release: got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_reset_abort();
    int cyc;
    int dones = 0;
    do_start(8'h0F, 8'hF0);
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (bus.bit_cnt !== 4'd4) begin
      errors++;
      $display("FAIL abort_position: got bit_cnt=%0d expected 4", bus.bit_cnt);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.L, bus.E, bus.G, bus.bit_cnt} !== 9'b0) begin
      errors++;
      $display("FAIL abort_state: got busy/done/LEG/cnt=%b expected 0", {bus.busy, bus.done, bus.L, bus.E, bus.G, bus.bit_cnt});
    end
    for (int i = 0; i < 10; i++) begin
      if (bus.done === 1'b1) dones++;
      step();
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses expected 0", dones);
    end
    do_start(8'hF0, 8'h0F);
    wait_done(cyc);
    checks++;
    if (cyc != 8 || {bus.L, bus.E, bus.G} !== 3'b001) begin
      errors++;
      $display("FAIL abort_restart: got cyc=%0d LEG=%b expected cyc=8 LEG=001", cyc, {bus.L, bus.E, bus.G});
    end
    step();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    test_reset();
    test_equal();
    test_msb_override();
    test_less_serial();
    test_start_while_busy();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
